// File: rtl/axi_read_responder.sv
// -----------------------------------------------------------------------------
// axi_read_responder
//
// Memory-side AXI4 read responder for the instruction-cache fetch path. It
// accepts one AR request at a time and returns a burst of 64-bit beats on the
// R channel from an internal word array. FIXED, INCR and WRAP bursts are
// supported, and R-channel backpressure via s_axi_rready is honoured. A side
// write port preloads program images into the array.
//
// Parameters:
//   mem_words    - depth of the word array (64-bit words)
//   read_latency - idle cycles between the AR handshake and the first rvalid
//                  (0..15)
//
// Ports:
//   clock, reset          - rising-edge clock, asynchronous active-low reset
//   s_axi_ar*             - read address channel (valid/ready/addr/len/size/burst)
//   s_axi_r*              - read data channel (valid/ready/data/resp/last)
//   mem_we/waddr/wdata    - preload write port, usable in any state
//   busy                  - high whenever a burst is in progress
// -----------------------------------------------------------------------------
module axi_read_responder #(
  parameter int mem_words    = 4096,
  parameter int read_latency = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         s_axi_arvalid,
  output logic                         s_axi_arready,
  input  logic [63:0]                  s_axi_araddr,
  input  logic [7:0]                   s_axi_arlen,
  input  logic [2:0]                   s_axi_arsize,
  input  logic [1:0]                   s_axi_arburst,
  output logic                         s_axi_rvalid,
  input  logic                         s_axi_rready,
  output logic [63:0]                  s_axi_rdata,
  output logic [1:0]                   s_axi_rresp,
  output logic                         s_axi_rlast,
  input  logic                         mem_we,
  input  logic [$clog2(mem_words)-1:0] mem_waddr,
  input  logic [63:0]                  mem_wdata,
  output logic                         busy
);

  localparam int AW = $clog2(mem_words);

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_WRAP  = 2'd2;
  localparam logic [1:0] BURST_RSVD  = 2'd3;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  lat_q,   lat_d;
  logic [7:0]  beat_q,  beat_d;
  logic [7:0]  len_q,   len_d;
  logic [1:0]  burst_q, burst_d;
  logic        err_q,   err_d;
  logic [63:0] addr_q,  addr_d;
  logic [63:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic        rlast_q, rlast_d;

  logic [63:0] mem [mem_words];

  logic        reqErr;
  logic [60:0] wordIdx;
  logic        inRange;
  logic        beatBad;
  logic [63:0] memWord;
  logic [63:0] beatData;
  logic [1:0]  beatResp;
  logic [63:0] wrapMask;
  logic [63:0] nextAddr;

  // Preload port. The array has no reset so program images survive a reset.
  // A beat register sampling the same word on this edge sees the old value
  // because both are updated non-blocking on the same edge.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Request check evaluated at the AR handshake; the result is latched and
  // poisons every beat of the burst.
  always_comb begin
    reqErr = 1'b0;
    if (s_axi_arsize != 3'd3) begin
      reqErr = 1'b1;
    end
    if (s_axi_arburst == BURST_RSVD) begin
      reqErr = 1'b1;
    end
    if (s_axi_arburst == BURST_WRAP &&
        !(s_axi_arlen == 8'd1 || s_axi_arlen == 8'd3 ||
          s_axi_arlen == 8'd7 || s_axi_arlen == 8'd15)) begin
      reqErr = 1'b1;
    end
  end

  // addr_q always holds the address of the next beat to be registered, so
  // the data path and the address step both work from it.
  always_comb begin
    wordIdx  = addr_q[63:3];
    inRange  = (wordIdx < 61'(mem_words));
    memWord  = mem[addr_q[AW+2:3]];
    beatBad  = err_q || !inRange;
    beatData = beatBad ? 64'd0 : memWord;
    beatResp = beatBad ? RESP_SLVERR : RESP_OKAY;
  end

  // Address step. The WRAP mask spans the whole burst in bytes; wrapping
  // only makes sense for the legal WRAP lengths, which the request check
  // already enforces. INCR wraps around the 64-bit space with no 4 KB check.
  always_comb begin
    wrapMask = (({56'd0, len_q} + 64'd1) << 3) - 64'd1;
    case (burst_q)
      BURST_FIXED: nextAddr = addr_q;
      BURST_WRAP:  nextAddr = (addr_q & ~wrapMask) |
                              ((addr_q + 64'd8) & wrapMask);
      default:     nextAddr = addr_q + 64'd8;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      lat_q   <= 4'd0;
      beat_q  <= 8'd0;
      len_q   <= 8'd0;
      burst_q <= 2'd0;
      err_q   <= 1'b0;
      addr_q  <= 64'd0;
      rdata_q <= 64'd0;
      rresp_q <= 2'd0;
      rlast_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      beat_q  <= beat_d;
      len_q   <= len_d;
      burst_q <= burst_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
      rresp_q <= rresp_d;
      rlast_q <= rlast_d;
    end
  end

  // Next-state logic. The output beat registers only change when a new beat
  // is loaded, which keeps rdata/rresp/rlast stable while the master stalls.
  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    beat_d  = beat_q;
    len_d   = len_q;
    burst_d = burst_q;
    err_d   = err_q;
    addr_d  = addr_q;
    rdata_d = rdata_q;
    rresp_d = rresp_q;
    rlast_d = rlast_q;

    case (state_q)
      IDLE: begin
        if (s_axi_arvalid) begin
          len_d   = s_axi_arlen;
          burst_d = s_axi_arburst;
          err_d   = reqErr;
          addr_d  = s_axi_araddr & ~64'h7;
          beat_d  = 8'd0;
          lat_d   = 4'(read_latency);
          state_d = WAIT;
        end
      end

      WAIT: begin
        if (lat_q == 4'd0) begin
          state_d = RESP;
          rdata_d = beatData;
          rresp_d = beatResp;
          rlast_d = (beat_q == len_q);
          addr_d  = nextAddr;
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end

      RESP: begin
        if (s_axi_rready) begin
          if (rlast_q) begin
            state_d = IDLE;
            rlast_d = 1'b0;
          end else begin
            beat_d  = beat_q + 8'd1;
            rdata_d = beatData;
            rresp_d = beatResp;
            rlast_d = ((beat_q + 8'd1) == len_q);
            addr_d  = nextAddr;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign s_axi_arready = (state_q == IDLE);
  assign s_axi_rvalid  = (state_q == RESP);
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rlast   = rlast_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: doc/axi_read_responder.md
# axi_read_responder

- Memory-side AXI4 read-channel responder: the slave end of the burst reads issued by the fetch-path instruction cache.
- Accepts one AR request at a time and returns a burst of 64-bit beats on the R channel from an internal word array.
- Supports FIXED, INCR and WRAP bursts and honours `rready` backpressure.
- Sits between the cache read master and backing memory; a side write port preloads program images.

## Interface
Parameters:
- `mem_words`, 4096 — depth of internal array in 64-bit words; byte range is 0 .. mem_words*8-1
- `read_latency`, 2 — idle cycles between AR handshake and the first beat's `rvalid`; range 0..15

Ports:
- `clock`  in  1  — sole clock, rising edge
- `reset`  in  1  — asynchronous, active-low
- `s_axi_arvalid`  in  1  — read address valid
- `s_axi_arready`  out  1  — read address ready
- `s_axi_araddr`  in  64  — burst start byte address
- `s_axi_arlen`  in  8  — beats minus one
- `s_axi_arsize`  in  3  — log2 bytes per beat
- `s_axi_arburst`  in  2  — 0 FIXED, 1 INCR, 2 WRAP, 3 reserved
- `s_axi_rvalid`  out  1  — read data valid
- `s_axi_rready`  in  1  — master ready for data
- `s_axi_rdata`  out  64  — beat data
- `s_axi_rresp`  out  2  — 0 OKAY, 2 SLVERR
- `s_axi_rlast`  out  1  — final beat of burst
- `mem_we`  in  1  — preload write enable
- `mem_waddr`  in  $clog2(mem_words)  — preload word index
- `mem_wdata`  in  64  — preload data
- `busy`  out  1  — a burst is in progress (state not IDLE)

## Operation
- **States:**
  - IDLE: `arready`=1. On `arvalid && arready`, latch the request, set the beat counter to 0 and go to WAIT.
  - WAIT: load the latency counter with `read_latency`. When it reaches 0, go to RESP and register the first beat. With `read_latency`=0, WAIT lasts one cycle.
  - RESP: `rvalid`=1. On `rvalid && rready`, increment the beat counter and register the next beat. If the accepted beat had `rlast`=1, go to IDLE instead.
- **Request check**, done at the handshake and applied to every beat of the burst: the burst is errored if any of the following hold.
  - `arsize` ≠ 3
  - `arburst` = 3
  - WRAP with `arlen` not in {1, 3, 7, 15}
- **Errored burst:** still returns `arlen`+1 beats, each with `rresp`=2 and `rdata`=0.
- **Beat address:**
  - First beat: `araddr` with bits [2:0] cleared.
  - FIXED: address unchanged for every beat.
  - INCR: +8 per beat; 64-bit wrap-around, with no 4 KB boundary check.
  - WRAP: mask = (arlen+1)*8-1; next = (addr & ~mask) | ((addr+8) & mask).
- **Out-of-range beat:** word index addr[63:3] ≥ `mem_words` gives `rresp`=2 and `rdata`=0 for that beat only. Other beats are unaffected.
- **Output register:** `rdata`, `rresp` and `rlast` are registered. They stay stable while `rvalid && !rready`. `rlast`=1 exactly when the beat counter equals the latched `arlen`.
- **Preload:** `mem_we` writes `mem_wdata` to `mem[mem_waddr]` on any clock edge, in any state. If a beat register loads the same word in the same cycle, it captures the old data (read-before-write).
- **Reset:** the array is not cleared by reset; contents persist across reset.

## Timing
- **Reset values (async assert):**
  - state IDLE
  - `arready`=1, `rvalid`=0, `rlast`=0, `rresp`=0, `rdata`=0, `busy`=0
  - counters 0
- **Reset mid-burst:** the burst is dropped immediately and no further beats are issued. The first request after deassertion is accepted normally.
- **Latency:** handshake at edge T gives the first `rvalid` at T+1+`read_latency`. Beats are back-to-back at one per cycle while `rready`=1.
- **`arready`:** deasserts in the cycle after the handshake. It reasserts in the cycle after the last beat is accepted; there is no request overlap.
- **Independence:** `rvalid` never depends combinationally on `rready`. `arready` depends only on state.
- **Early `rready`:** `rready` high before `rvalid` has no effect.
- **Simultaneous `arvalid` and last beat accept:** the request is not accepted that cycle. It is accepted the next cycle if still asserted.
- **`arlen`=255 INCR:** 256 beats. The beat counter is 8 bits and must not overflow before `rlast`.

## Test plan
- **Cache wrap fill:** preload `mem[i]`=i for i=0x200..0x207; AR `araddr`=0x1038, `arlen`=7, `arsize`=3, `arburst`=2, `rready`=1 -> 8 beats with data 0x207, 0x200, 0x201 … 0x206, all `rresp`=0, `rlast` on beat 8 only, first `rvalid` 3 cycles after handshake.
- **Backpressure:** INCR `araddr`=0x0, `arlen`=3, `rready` toggling 1,0,0,1,… -> `rdata`/`rlast` held while stalled; exactly 4 accepted beats with data `mem[0..3]`; `arready` high the cycle after the last accept.
- **Range/error:** INCR `araddr`=(mem_words-2)*8, `arlen`=3 -> beats 1-2 OKAY with array data, beats 3-4 SLVERR with data 0. `arsize`=2, `arlen`=1 -> 2 beats, SLVERR, data 0.
- **FIXED + preload collision:** FIXED `araddr`=0x40, `arlen`=2, with `mem_we` to word 8 (new=0xBEEF) on the cycle beat 2 is loaded -> beats 1-2 old value, beat 3 0xBEEF.
- **Reset mid-burst:** assert `reset` low during beat 3 of an 8-beat burst -> `rvalid`=0 and `arready`=1 immediately; after release, a new AR with `arlen`=0 returns a single beat with `rlast`=1.
- **`read_latency`=0 build:** `arlen`=0 -> `rvalid` the cycle after the handshake; `busy` high for exactly 2 cycles.
